tile_renderer: RTL

Background tile rendering stage that sits directly upstream of `sprite_rom`. It maps the VGA controller's current pixel coordinates onto a 20x15 grid of 32x32 tiles and reads a per-tile type from an internal tile map. It then drives `sprite_rom` with `{tile_type, row}`, selects the addressed bit from the returned 32-bit row, and produces registered RGB. The NIOS-side map write port updates the tile map. After reset, a clear sequencer loads a default room: walls on the border, floor everywhere else.

---
 rtl/tile_renderer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tile_renderer.sv
// Background tile renderer: 20x15 map of 32x32 tiles feeding sprite_rom, two-stage pixel pipeline.
// Optional grid overlay enabled by defining TILE_RENDERER_GRID_EN.
module tile_renderer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_data,
    input  logic        map_we,
    input  logic [8:0]  map_addr,
    input  logic        map_wdata,
    output logic        map_ready,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue
);

    // state   | meaning
    // S_CLEAR | loading the default room, one map entry per cycle; output forced black
    // S_RUN   | rendering; host map writes accepted
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    localparam logic [23:0] WALL_FG  = 24'hC0C0C0;
    localparam logic [23:0] WALL_BG  = 24'h404040;
    localparam logic [23:0] FLOOR_FG = 24'h8B5A2B;
    localparam logic [23:0] FLOOR_BG = 24'h000000;
`ifdef TILE_RENDERER_GRID_EN
    localparam logic [23:0] GRID_COLOR = 24'hFF0000;
`endif

    localparam logic [9:0] MAP_SIZE = 10'd300;

    logic [0:0]  r_state;
    logic [8:0]  r_clr_cnt;
    logic [3:0]  r_clr_row;
    logic [4:0]  r_clr_col;
    logic        r_map [0:299];

    logic [4:0]  r_x_s1;
    logic [4:0]  r_y_s1;
    logic        r_blank_s1;
    logic        r_on_s1;
    logic        r_tile_s1;
    logic [23:0] r_rgb;

    logic [9:0]  w_rd_idx;
    logic        w_clr_wall;
    logic        w_we;
    logic [8:0]  w_waddr;
    logic        w_wdata;
    logic        w_pix;
    logic [23:0] w_rgb;

    assign w_rd_idx   = 10'(DrawY[9:5]) * 10'd20 + 10'(DrawX[9:5]);
    assign w_clr_wall = (r_clr_row == 4'd0) || (r_clr_row == 4'd14) ||
                        (r_clr_col == 5'd0) || (r_clr_col == 5'd19);

    // The clear sequencer owns the write port until RUN; host writes before then are dropped.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = 9'd0;
        w_wdata = 1'b0;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = ~w_clr_wall;
        end else if (map_we && (map_addr < 9'd300)) begin
            w_we    = 1'b1;
            w_waddr = map_addr;
            w_wdata = map_wdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= 9'd0;
            r_clr_row <= 4'd0;
            r_clr_col <= 5'd0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_cnt == 9'd299) begin
                r_state <= S_RUN;
            end
            r_clr_cnt <= r_clr_cnt + 9'd1;
            if (r_clr_col == 5'd19) begin
                r_clr_col <= 5'd0;
                r_clr_row <= r_clr_row + 4'd1;
            end else begin
                r_clr_col <= r_clr_col + 5'd1;
            end
        end
    end

    assign map_ready = (r_state == S_RUN);

    // Map storage has no reset; the clear sequencer initialises it after every reset.
    always_ff @(posedge Clk) begin
        if (w_we) begin
            r_map[w_waddr] <= w_wdata;
        end
    end

    // Stage S0: registered map read (old data on a same-cycle write) plus coordinate capture.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x_s1     <= 5'd0;
            r_y_s1     <= 5'd0;
            r_blank_s1 <= 1'b0;
            r_on_s1    <= 1'b0;
            r_tile_s1  <= 1'b0;
        end else begin
            r_x_s1     <= DrawX[4:0];
            r_y_s1     <= DrawY[4:0];
            r_blank_s1 <= blank;
            r_on_s1    <= (DrawX < 10'd640) && (DrawY < 10'd480);
            r_tile_s1  <= (w_rd_idx < MAP_SIZE) ? r_map[w_rd_idx[8:0]] : 1'b0;
        end
    end

    assign rom_addr = {r_tile_s1, r_y_s1};
    assign w_pix    = rom_data[5'd31 - r_x_s1];

    always_comb begin
        w_rgb = 24'h000000;
        if (r_blank_s1 && r_on_s1 && (r_state == S_RUN)) begin
            if (r_tile_s1) begin
                w_rgb = w_pix ? FLOOR_FG : FLOOR_BG;
            end else begin
                w_rgb = w_pix ? WALL_FG : WALL_BG;
            end
`ifdef TILE_RENDERER_GRID_EN
            if ((r_x_s1 == 5'd0) || (r_y_s1 == 5'd0)) begin
                w_rgb = GRID_COLOR;
            end
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rgb <= 24'h000000;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign Red   = r_rgb[23:16];
    assign Green = r_rgb[15:8];
    assign Blue  = r_rgb[7:0];

endmodule
